rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 23 ++
 rtl/rst_seq_sync_2ff.sv | 25 ++
 rtl/rst_seq.sv | 153 +++++++++++++++
 tb/tb_rst_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause encodings
// and a small elaboration-time helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_RUN       = 2'd2,
        ST_ASSERT    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR       = 2'b00,
        CAUSE_SW        = 2'b01,
        CAUSE_WDT       = 2'b10,
        CAUSE_LOCK_LOSS = 2'b11
    } cause_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops clear
// on reset so the synchronised value reads 0 until the input is sampled.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: waits for PLL lock, releases the domain resets one by one
// with a programmable gap, and re-asserts them all on SW/WDT/lock-loss events.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_LOCK | all domains held in reset, waiting for synchronised lock
//   RELEASE   | counting down dly_i between successive domain releases
//   RUN       | all domains released, seq_done_o high, watching for events
//   ASSERT    | all domains held in reset for HOLD_CYC cycles after an event
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM  = 4,
    parameter int DLY_W    = 8,
    parameter int HOLD_CYC = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               pll_lock_i,
    input  logic               sw_rst_req_i,
    input  logic               wdt_rst_req_i,
    input  logic [DLY_W-1:0]   dly_i,
    output logic [NUM_DOM-1:0] dom_rst_n_o,
    output logic               seq_done_o,
    output logic [1:0]         rst_cause_o
);

    localparam int IDX_W = $clog2(NUM_DOM + 1);
    localparam int CNT_W = max_int(DLY_W, $clog2(HOLD_CYC));

    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);

    logic               lock_s;
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_DOM-1:0] dom_q, dom_d;
    logic               done_q, done_d;
    cause_t             cause_q, cause_d;
    logic [CNT_W-1:0]   dly_ext;
    logic               event_hit;
    cause_t             event_cause;

    sync_2ff u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (pll_lock_i),
        .q_o     (lock_s)
    );

    assign dly_ext   = CNT_W'(dly_i);
    assign event_hit = !lock_s || wdt_rst_req_i || sw_rst_req_i;

    // Lock loss outranks the watchdog, which outranks software.
    always_comb begin
        event_cause = CAUSE_SW;
        if (!lock_s) begin
            event_cause = CAUSE_LOCK_LOSS;
        end else if (wdt_rst_req_i) begin
            event_cause = CAUSE_WDT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_WAIT_LOCK;
            idx_q   <= '0;
            cnt_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        done_d  = done_q;
        cause_d = cause_q;

        unique case (state_q)
            ST_WAIT_LOCK: begin
                dom_d  = '0;
                done_d = 1'b0;
                if (lock_s) begin
                    state_d = ST_RELEASE;
                    idx_d   = '0;
                    cnt_d   = dly_ext;
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (event_hit) begin
                    state_d = ST_ASSERT;
                    idx_d   = '0;
                    cnt_d   = HOLD_LD;
                    dom_d   = '0;
                    done_d  = 1'b0;
                    cause_d = event_cause;
                end else if (state_q == ST_RELEASE) begin
                    if (cnt_q == '0) begin
                        for (int k = 0; k < NUM_DOM; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                dom_d[k] = 1'b1;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                        cnt_d = dly_ext;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            ST_ASSERT: begin
                dom_d  = '0;
                done_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_WAIT_LOCK;
                idx_d   = '0;
                cnt_d   = '0;
                dom_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign dom_rst_n_o = dom_q;
    assign seq_done_o  = done_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: event-time reference model checked every cycle, directed
// scenarios pinned with hand-computed cycle numbers, then randomized traffic.
module tb_rst_seq;

    localparam int NUM_DOM  = 4;
    localparam int DLY_W    = 8;
    localparam int HOLD_CYC = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               lock = 1'b0;
    logic               sw = 1'b0;
    logic               wdt = 1'b0;
    logic [DLY_W-1:0]   dly = '0;
    logic [NUM_DOM-1:0] dom;
    logic               done;
    logic [1:0]         cause;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit check_en = 1'b0;
    int rel_at[NUM_DOM];
    int done_at;

    // Model state, expressed as event times rather than FSM states.
    int       m_t = 0;
    int       m_nrel = 0;
    int       m_next = 0;
    int       m_hold_end = -1;
    bit       m_armed = 1'b0;
    logic [1:0] m_cause = 2'd0;
    logic [1:0] m_pipe = 2'd0;

    rst_seq #(
        .NUM_DOM  (NUM_DOM),
        .DLY_W    (DLY_W),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .pll_lock_i    (lock),
        .sw_rst_req_i  (sw),
        .wdt_rst_req_i (wdt),
        .dly_i         (dly),
        .dom_rst_n_o   (dom),
        .seq_done_o    (done),
        .rst_cause_o   (cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lock seen by the sequencer is the pin value two edges old. A sequence
    // arms on the first edge past the hold window with lock seen; domain n
    // releases dly+1 edges after the previous reload.
    always @(posedge clk or negedge rst_n) begin : model
        int t, nrel, nxt, hold_end;
        bit armed;
        logic [1:0] c;
        if (!rst_n) begin
            m_pipe     <= 2'd0;
            m_armed    <= 1'b0;
            m_nrel     <= 0;
            m_next     <= 0;
            m_hold_end <= -1;
            m_t        <= 0;
            m_cause    <= 2'd0;
        end else begin
            t        = m_t + 1;
            nrel     = m_nrel;
            nxt      = m_next;
            hold_end = m_hold_end;
            armed    = m_armed;
            c        = m_cause;
            if (armed) begin
                if (!m_pipe[1] || wdt || sw) begin
                    c        = !m_pipe[1] ? 2'd3 : (wdt ? 2'd2 : 2'd1);
                    armed    = 1'b0;
                    nrel     = 0;
                    hold_end = t + HOLD_CYC;
                end else if (nrel < NUM_DOM && t == nxt) begin
                    nrel = nrel + 1;
                    nxt  = t + int'(dly) + 1;
                end
            end else if (t > hold_end && m_pipe[1]) begin
                armed = 1'b1;
                nrel  = 0;
                nxt   = t + int'(dly) + 1;
            end
            m_t        <= t;
            m_nrel     <= nrel;
            m_next     <= nxt;
            m_hold_end <= hold_end;
            m_armed    <= armed;
            m_cause    <= c;
            m_pipe     <= {m_pipe[0], lock};
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_dom", int'(dom), (1 << m_nrel) - 1);
            check("model_done", int'(done), int'(m_armed && m_nrel == NUM_DOM));
            check("model_cause", int'(cause), int'(m_cause));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        lock  = 1'b0;
        sw    = 1'b0;
        wdt   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dom", int'(dom), 0);
        check("rst_done", int'(done), 0);
        check("rst_cause", int'(cause), 0);
        rst_n = 1'b1;
    endtask

    // Records the first cycle (relative to the call) each domain and
    // seq_done are seen high; optionally rewrites dly at a given cycle.
    task automatic measure(input int budget, input int chg_at, input logic [DLY_W-1:0] chg_val);
        int base;
        base = cyc;
        for (int k = 0; k < NUM_DOM; k++) rel_at[k] = -1;
        done_at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_DOM; k++) begin
                if (rel_at[k] < 0 && dom[k]) rel_at[k] = cyc - base;
            end
            if (done_at < 0 && done) done_at = cyc - base;
            if (cyc - base == chg_at) dly = chg_val;
        end
    endtask

    initial begin
        int high_seen;

        do_reset();
        check_en = 1'b1;

        // POR sequence, dly=3: releases at 7, 11, 15, 19.
        dly = 8'd3;
        @(negedge clk);
        lock = 1'b1;
        measure(30, -1, '0);
        check("por_rel0", rel_at[0], 7);
        check("por_rel1", rel_at[1], 11);
        check("por_rel2", rel_at[2], 15);
        check("por_rel3", rel_at[3], 19);
        check("por_done", done_at, 19);
        check("por_cause", int'(cause), 0);

        // SW and WDT together in RUN: WDT wins, 16-cycle hold, restart.
        dly = 8'd0;
        sw  = 1'b1;
        wdt = 1'b1;
        @(negedge clk);
        sw  = 1'b0;
        wdt = 1'b0;
        check("evt_dom_low", int'(dom), 0);
        check("evt_cause_wdt", int'(cause), 2);
        check("evt_done_low", int'(done), 0);
        measure(30, -1, '0);
        check("evt_restart_rel0", rel_at[0], 18);
        check("evt_restart_rel3", rel_at[3], 21);
        check("evt_restart_done", done_at, 21);

        // dly=0 from POR: consecutive releases.
        do_reset();
        dly = 8'd0;
        @(negedge clk);
        lock = 1'b1;
        measure(15, -1, '0);
        check("d0_rel0", rel_at[0], 4);
        check("d0_rel1", rel_at[1], 5);
        check("d0_rel2", rel_at[2], 6);
        check("d0_rel3", rel_at[3], 7);
        check("d0_done", done_at, 7);

        // dly 3 -> 1 mid-count: only the next reload picks it up.
        do_reset();
        dly = 8'd3;
        @(negedge clk);
        lock = 1'b1;
        measure(25, 8, 8'd1);
        check("dchg_rel0", rel_at[0], 7);
        check("dchg_rel1", rel_at[1], 11);
        check("dchg_rel2", rel_at[2], 13);
        check("dchg_rel3", rel_at[3], 15);

        // Lock loss after domain 1 released (dly=2: domains at 6, 9).
        do_reset();
        dly = 8'd2;
        @(negedge clk);
        lock = 1'b1;
        repeat (9) @(negedge clk);
        check("ll_pre_dom", int'(dom), 3);
        lock = 1'b0;
        repeat (3) @(negedge clk);
        check("ll_dom_low", int'(dom), 0);
        check("ll_cause", int'(cause), 3);
        high_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dom != '0) high_seen++;
        end
        check("ll_no_release", high_seen, 0);
        lock = 1'b1;
        measure(20, -1, '0);
        check("ll_restart_rel0", rel_at[0], 6);
        check("ll_restart_rel3", rel_at[3], 15);

        // rst_n pulsed mid-ASSERT: immediate reset values, full POR again.
        do_reset();
        dly = 8'd1;
        @(negedge clk);
        lock = 1'b1;
        repeat (15) @(negedge clk);
        sw = 1'b1;
        @(negedge clk);
        sw = 1'b0;
        repeat (5) @(negedge clk);
        check("rstmid_cause_sw", int'(cause), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_dom", int'(dom), 0);
        check("rstmid_done", int'(done), 0);
        check("rstmid_cause", int'(cause), 0);
        @(negedge clk);
        rst_n = 1'b1;
        measure(20, -1, '0);
        check("rstmid_rel0", rel_at[0], 5);
        check("rstmid_rel1", rel_at[1], 7);
        check("rstmid_rel2", rel_at[2], 9);
        check("rstmid_rel3", rel_at[3], 11);
        check("rstmid_done_at", done_at, 11);

        // Randomized traffic against the model.
        do_reset();
        lock = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            sw  = ($urandom_range(0, 39) == 0);
            wdt = ($urandom_range(0, 59) == 0);
            if (lock ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 19) == 0))
                lock = ~lock;
            if ($urandom_range(0, 29) == 0)
                dly = DLY_W'($urandom_range(0, 4));
            if ($urandom_range(0, 899) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rand_async_dom", int'(dom), 0);
                check("rand_async_cause", int'(cause), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        sw  = 1'b0;
        wdt = 1'b0;
        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
